edit_mode_ctrl: RTL and testbench
=================================

// Module: edit_mode_ctrl
// PURPOSE
//  Sequences the time/date counters' manual-edit interface from debounced buttons.
//  Drives set_mode, field_sel, display_sel and single-cycle inc/dec strobes into the counter chain.
//  Counters AND these strobes with set_mode/field_sel/display_sel exactly as today.
//  Sits between btn_deb_onepulse_ce instances and the counter_mod60/mod24/ngay/thang/nam chain.
// PARAMETERS
//  TIMEOUT_MS      10000  idle ms in EDIT before forced return to RUN (>=2)
//  REPEAT_DELAY_MS 500    hold time before first auto-repeat strobe (AUTO_REPEAT_EN only)
//  REPEAT_RATE_MS  100    period between auto-repeat strobes (AUTO_REPEAT_EN only)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous reset, active-low
//  tick_ms      in   1  1 kHz clock-enable, one clk wide (ce_gen output)
//  mode_p       in   1  press pulse: enter/leave EDIT
//  sel_p        in   1  press pulse: next field in EDIT
//  view_p       in   1  press pulse: toggle TIME/DATE view in RUN
//  up_p, down_p in   1  press pulses: increment/decrement selected field
//  up_held      in   1  debounced level, up button pressed
//  down_held    in   1  debounced level, down button pressed
//  set_mode     out  1  1 = EDIT state
//  field_sel    out  2  00 none, 01 sec/day, 10 min/month, 11 hour/year
//  display_sel  out  1  1 = DATE view, 0 = TIME view
//  inc_p        out  1  one-cycle increment strobe
//  dec_p        out  1  one-cycle decrement strobe
//  timeout_p    out  1  one-cycle pulse when EDIT exits by timeout
// BEHAVIOUR
//  Reset: state RUN, set_mode=0, field_sel=00, display_sel=0, inc_p=dec_p=timeout_p=0, all counters 0.
//  Every output is registered; a response appears on the clk edge after the input pulse (1-cycle latency).
//  RUN:
//   - view_p toggles display_sel.
//   - mode_p -> EDIT, field_sel=01; display_sel is held.
//   - up_p/down_p ignored; inc_p/dec_p stay 0.
//  EDIT:
//   - sel_p cycles field_sel 01->10->11->01.
//   - mode_p -> RUN, field_sel=00.
//   - view_p ignored (view is frozen while editing).
//   - up_p -> inc_p=1 for one cycle; down_p -> dec_p=1 for one cycle.
//  Simultaneous pulses:
//   - up_p&down_p same cycle -> no strobe.
//   - mode_p beats sel_p, view_p, up_p and down_p; in EDIT a mode_p cycle emits no strobe.
//  Idle timer:
//   - 16-bit counter, counts tick_ms in EDIT only.
//   - Cleared on any button pulse or held level, and on entry to EDIT.
//   - When it reaches TIMEOUT_MS-1 and tick_ms=1: -> RUN, field_sel=00, timeout_p=1 for one cycle.
//   - Button activity in the same cycle wins: no timeout, timer cleared.
//  Counter wrap and range are owned by the counters; this block never saturates or checks range.
//  Reset mid-EDIT returns to RUN with the idle timer cleared and no pending strobes.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//   - In EDIT, up_held (exclusive of down_held) held continuously for REPEAT_DELAY_MS ticks
//     after its press pulse gives inc_p; then one inc_p every REPEAT_RATE_MS ticks.
//   - down_held is symmetric and produces dec_p.
//   - Repeat counter clears on release, on both held, on sel_p/mode_p, or on leaving EDIT.
//   - A held button keeps the idle timer cleared.
//  AUTO_REPEAT_EN undefined:
//   - Only press pulses produce strobes.
//   - Held levels still clear the idle timer; no repeat logic is synthesised.
// TESTING
//  1 Reset, then view_p -> display_sel=1; mode_p -> set_mode=1, field_sel=01, display_sel stays 1.
//  2 In EDIT: sel_p x3 -> field_sel 10, 11, 01; up_p -> exactly one inc_p; up_p+down_p same cycle -> none.
//  3 In EDIT with view_p -> display_sel unchanged; mode_p+sel_p same cycle -> RUN, field_sel=00.
//  4 TIMEOUT_MS=20, enter EDIT, no buttons -> after 20 ticks: set_mode=0, timeout_p one cycle;
//    up_p at tick 19 -> no timeout.
//  5 AUTO_REPEAT_EN, DELAY=5, RATE=2: up_p then up_held 12 ticks -> inc_p at press, tick 5, 7, 9, 11;
//    release -> none.
//  6 Assert rst_n=0 mid-repeat in EDIT -> all outputs at reset values; no inc_p after release of reset.

Source files
------------

// File: rtl/edit_mode_ctrl.sv
// Manual-edit sequencer for the time/date counter chain: RUN/EDIT state, field select,
// view select, registered inc/dec strobes and an idle timeout. Define AUTO_REPEAT_EN for hold-repeat.
module edit_mode_ctrl #(
  parameter int unsigned TIMEOUT_MS      = 10000,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ms,
  input  logic       mode_p,
  input  logic       sel_p,
  input  logic       view_p,
  input  logic       up_p,
  input  logic       down_p,
  input  logic       up_held,
  input  logic       down_held,
  output logic       set_mode,
  output logic [1:0] field_sel,
  output logic       display_sel,
  output logic       inc_p,
  output logic       dec_p,
  output logic       timeout_p
);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StEdit = 1'b1;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_MS - 1);

  if (TIMEOUT_MS < 2 || TIMEOUT_MS > 65536 ||
      REPEAT_DELAY_MS < 1 || REPEAT_DELAY_MS > 65535 ||
      REPEAT_RATE_MS < 1 || REPEAT_RATE_MS > 65535) begin : g_bad_cfg
    $error("edit_mode_ctrl: timing parameter out of range");
  end

  logic [0:0]  state_q, state_d;
  logic [1:0]  field_q, field_d;
  logic        view_q, view_d;
  logic        inc_q, inc_d;
  logic        dec_q, dec_d;
  logic        to_q, to_d;
  logic [15:0] idle_q, idle_d;

  logic        rep_inc, rep_dec;
  logic        activity;

  // Held levels count as activity so a long press never times out.
  assign activity = mode_p | sel_p | view_p | up_p | down_p | up_held | down_held;

`ifdef AUTO_REPEAT_EN
  localparam logic [15:0] DelayTicks = 16'(REPEAT_DELAY_MS);
  localparam logic [15:0] RateTicks  = 16'(REPEAT_RATE_MS);

  logic        armed_q, armed_d;
  logic        dir_up_q, dir_up_d;
  logic        first_q, first_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_nx;
  logic        held_ok;

  assign held_ok = dir_up_q ? (up_held & ~down_held) : (down_held & ~up_held);
  assign cnt_nx  = cnt_q + 16'd1;

  // A press arms the repeater; ticks are then counted while only that button stays held.
  always_comb begin
    armed_d  = armed_q;
    dir_up_d = dir_up_q;
    first_d  = first_q;
    cnt_d    = cnt_q;
    rep_inc  = 1'b0;
    rep_dec  = 1'b0;
    if (state_q != StEdit || mode_p || sel_p || (up_p & down_p)) begin
      armed_d = 1'b0;
      first_d = 1'b0;
      cnt_d   = '0;
    end else if (up_p ^ down_p) begin
      armed_d  = 1'b1;
      dir_up_d = up_p;
      first_d  = 1'b0;
      cnt_d    = '0;
    end else if (armed_q) begin
      if (!held_ok) begin
        armed_d = 1'b0;
        first_d = 1'b0;
        cnt_d   = '0;
      end else if (tick_ms) begin
        if (cnt_nx == (first_q ? RateTicks : DelayTicks)) begin
          rep_inc = dir_up_q;
          rep_dec = ~dir_up_q;
          first_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_nx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      dir_up_q <= 1'b0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      armed_q  <= armed_d;
      dir_up_q <= dir_up_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    view_d  = view_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    to_d    = 1'b0;
    idle_d  = '0;
    unique case (state_q)
      StRun: begin
        if (mode_p) begin
          state_d = StEdit;
          field_d = 2'b01;
        end else if (view_p) begin
          view_d = ~view_q;
        end
      end
      StEdit: begin
        if (mode_p) begin
          state_d = StRun;
          field_d = 2'b00;
        end else begin
          if (sel_p) begin
            field_d = (field_q == 2'b11) ? 2'b01 : field_q + 2'b01;
          end
          inc_d = (up_p & ~down_p) | rep_inc;
          dec_d = (down_p & ~up_p) | rep_dec;
          if (!activity && tick_ms) begin
            if (idle_q == TimeoutLast) begin
              state_d = StRun;
              field_d = 2'b00;
              to_d    = 1'b1;
            end else begin
              idle_d = idle_q + 16'd1;
            end
          end else if (!activity) begin
            idle_d = idle_q;
          end
        end
      end
      default: begin
        state_d = StRun;
        field_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      field_q <= 2'b00;
      view_q  <= 1'b0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      to_q    <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      view_q  <= view_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
    end
  end

  assign set_mode    = (state_q == StEdit);
  assign field_sel   = field_q;
  assign display_sel = view_q;
  assign inc_p       = inc_q;
  assign dec_p       = dec_q;
  assign timeout_p   = to_q;

endmodule

// File: tb/tb_edit_mode_ctrl.sv
// Directed plus randomized bench for edit_mode_ctrl against a behavioural model.
module tb_edit_mode_ctrl;
  localparam int unsigned TO = 20;
  localparam int unsigned DL = 5;
  localparam int unsigned RT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_ms = 1'b0, mode_p = 1'b0, sel_p = 1'b0, view_p = 1'b0;
  logic       up_p = 1'b0, down_p = 1'b0, up_held = 1'b0, down_held = 1'b0;
  logic       set_mode, display_sel, inc_p, dec_p, timeout_p;
  logic [1:0] field_sel;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         m_edit, m_view, m_armed, m_dir_up;
  logic [1:0] m_field;
  int         m_idle, m_ht;
  bit         e_inc, e_dec, e_to;

  edit_mode_ctrl #(
    .TIMEOUT_MS     (TO),
    .REPEAT_DELAY_MS(DL),
    .REPEAT_RATE_MS (RT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_ms    (tick_ms),
    .mode_p     (mode_p),
    .sel_p      (sel_p),
    .view_p     (view_p),
    .up_p       (up_p),
    .down_p     (down_p),
    .up_held    (up_held),
    .down_held  (down_held),
    .set_mode   (set_mode),
    .field_sel  (field_sel),
    .display_sel(display_sel),
    .inc_p      (inc_p),
    .dec_p      (dec_p),
    .timeout_p  (timeout_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edit = 0; m_view = 0; m_armed = 0; m_dir_up = 0; m_field = 2'b00;
    m_idle = 0; m_ht = 0; e_inc = 0; e_dec = 0; e_to = 0;
  endtask

  task automatic model_step();
    bit act;
    act = mode_p | sel_p | view_p | up_p | down_p | up_held | down_held;
    e_inc = 0; e_dec = 0; e_to = 0;
    if (!m_edit) begin
      if (mode_p) begin m_edit = 1; m_field = 2'b01; end
      else if (view_p) m_view = !m_view;
      m_idle = 0; m_armed = 0;
    end else if (mode_p) begin
      m_edit = 0; m_field = 2'b00; m_idle = 0; m_armed = 0;
    end else begin
      if (sel_p) m_field = (m_field == 2'd3) ? 2'd1 : m_field + 2'd1;
      if (up_p && !down_p) e_inc = 1;
      if (down_p && !up_p) e_dec = 1;
`ifdef AUTO_REPEAT_EN
      if (sel_p || (up_p && down_p)) m_armed = 0;
      else if (up_p || down_p) begin m_armed = 1; m_dir_up = up_p; m_ht = 0; end
      else if (m_armed) begin
        if (m_dir_up ? (up_held && !down_held) : (down_held && !up_held)) begin
          if (tick_ms) begin
            m_ht++;
            if (m_ht == DL || (m_ht > DL && (m_ht - DL) % RT == 0)) begin
              if (m_dir_up) e_inc = 1; else e_dec = 1;
            end
          end
        end else m_armed = 0;
      end
`endif
      if (act) m_idle = 0;
      else if (tick_ms) begin
        m_idle++;
        if (m_idle == TO) begin
          e_to = 1; m_edit = 0; m_field = 2'b00; m_idle = 0; m_armed = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, ".set_mode"}, {1'b0, set_mode}, {1'b0, m_edit});
    chk({ctx, ".field_sel"}, field_sel, m_field);
    chk({ctx, ".display_sel"}, {1'b0, display_sel}, {1'b0, m_view});
    chk({ctx, ".inc_p"}, {1'b0, inc_p}, {1'b0, e_inc});
    chk({ctx, ".dec_p"}, {1'b0, dec_p}, {1'b0, e_dec});
    chk({ctx, ".timeout_p"}, {1'b0, timeout_p}, {1'b0, e_to});
  endtask

  task automatic step(input string ctx, input bit t, m, s, v, u, d, uh, dh);
    tick_ms = t; mode_p = m; sel_p = s; view_p = v;
    up_p = u; down_p = d; up_held = uh; down_held = dh;
    @(posedge clk);
    #1;
    model_step();
    compare_all(ctx);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n_inc;
    bit uh, dh, u, d;
    model_reset();
    apply_reset();

    // 1: view toggle in RUN, enter EDIT keeps view
    step("run_view", 0, 0, 0, 1, 0, 0, 0, 0);
    chk("view_set", {1'b0, display_sel}, 2'd1);
    step("run_up_ignored", 0, 0, 0, 0, 1, 0, 0, 0);
    step("enter_edit", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("enter_field", field_sel, 2'b01);

    // 2: field cycling and strobes
    step("sel1", 0, 0, 1, 0, 0, 0, 0, 0);
    step("sel2", 0, 0, 1, 0, 0, 0, 0, 0);
    step("sel3", 0, 0, 1, 0, 0, 0, 0, 0);
    chk("field_wrap", field_sel, 2'b01);
    step("up", 0, 0, 0, 0, 1, 0, 0, 0);
    chk("up_inc", {1'b0, inc_p}, 2'd1);
    step("after_up", 0, 0, 0, 0, 0, 0, 0, 0);
    step("down", 0, 0, 0, 0, 0, 1, 0, 0);
    step("up_down", 0, 0, 0, 0, 1, 1, 0, 0);
    chk("up_down_none", {inc_p, dec_p}, 2'b00);

    // 3: view frozen in EDIT, mode beats sel
    step("edit_view", 0, 0, 0, 1, 0, 0, 0, 0);
    step("mode_sel", 0, 1, 1, 0, 1, 0, 0, 0);
    chk("mode_sel_field", field_sel, 2'b00);

    // 4: idle timeout, and activity on the deciding tick
    step("enter_to", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < int'(TO) - 1; i++) step("idle", 1, 0, 0, 0, 0, 0, 0, 0);
    step("up_at_last_tick", 1, 0, 0, 0, 1, 0, 0, 0);
    chk("no_timeout", {set_mode, timeout_p}, 2'b10);
    for (int i = 0; i < int'(TO) - 1; i++) step("idle2", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("still_edit", {1'b0, set_mode}, 2'd1);
    step("last_tick", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("timeout_fired", {set_mode, timeout_p}, 2'b01);
    step("after_to", 0, 0, 0, 0, 0, 0, 0, 0);

    // 5: hold repeat
    step("enter_rep", 0, 1, 0, 0, 0, 0, 0, 0);
    step("press", 0, 0, 0, 0, 1, 0, 1, 0);
    n_inc = int'(inc_p);
    for (int i = 0; i < 12; i++) begin
      step("hold_tick", 1, 0, 0, 0, 0, 0, 1, 0);
      n_inc += int'(inc_p);
      step("hold", 0, 0, 0, 0, 0, 0, 1, 0);
      n_inc += int'(inc_p);
    end
    for (int i = 0; i < 8; i++) begin
      step("released", 1, 0, 0, 0, 0, 0, 0, 0);
      n_inc += int'(inc_p);
    end
`ifdef AUTO_REPEAT_EN
    chk("repeat_count", n_inc[1:0], 2'd1);
    chk("repeat_total", {1'b0, n_inc == 5}, 2'd1);
`else
    chk("repeat_count", {1'b0, n_inc == 1}, 2'd1);
`endif

    // 6: reset in the middle of a repeat
    step("press2", 0, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step("hold2", 1, 0, 0, 0, 0, 0, 1, 0);
    apply_reset();
    n_inc = 0;
    for (int i = 0; i < 12; i++) begin
      step("post_reset", 1, 0, 0, 0, 0, 0, 1, 0);
      n_inc += int'(inc_p);
    end
    chk("post_reset_inc", {1'b0, n_inc == 0}, 2'd1);

    // Randomized traffic
    uh = 0; dh = 0;
    for (int i = 0; i < 3000; i++) begin
      u = 0; d = 0;
      if ($urandom_range(39) == 0) begin uh = !uh; u = uh; end
      if ($urandom_range(39) == 0) begin dh = !dh; d = dh; end
      step("rand", $urandom_range(2) == 0, $urandom_range(59) == 0, $urandom_range(19) == 0,
           $urandom_range(19) == 0, u, d, uh, dh);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
